// File: rtl/xilinx_single_port_ram_bytewe_pipe.sv
// Single-port no-change block RAM with per-byte-column write enables and a 1- or 2-stage read pipeline.
// Define RAM_CLEAR_ON_RESET_EN to sweep INIT_VALUE through the array after every reset.
module xilinx_single_port_ram_bytewe_pipe #(
  parameter int NB_COL      = 4,
  parameter int COL_WIDTH   = 8,
  parameter int RAM_DEPTH   = 1024,
  parameter int RAM_LATENCY = 2,
  parameter logic [NB_COL*COL_WIDTH-1:0] INIT_VALUE = '0,
  localparam int RAM_WIDTH  = NB_COL * COL_WIDTH,
  localparam int AW         = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                 clka,
  input  logic                 rsta_n,
  input  logic                 ena,
  input  logic [NB_COL-1:0]    wea,
  input  logic [AW-1:0]        addra,
  input  logic [RAM_WIDTH-1:0] dina,
  input  logic                 regcea,
  output logic [RAM_WIDTH-1:0] douta,
  output logic                 douta_valid,
  output logic                 init_busy
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(RAM_DEPTH);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  logic                 acc;
  logic                 wr;
  logic                 rd;
  logic                 in_range;
  logic                 clr_we;
  logic [AW-1:0]        clr_addr;
  logic [RAM_WIDTH-1:0] rdata_p1_q;
  logic                 vld_p1_q;

`ifdef RAM_CLEAR_ON_RESET_EN
  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;

  localparam logic [AW-1:0] LAST_C = AW'(RAM_DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == LAST_C) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: ;
    endcase
  end

  assign clr_addr  = cnt_q;
  assign init_busy = (state_q == CLEAR);
`else
  assign clr_we    = 1'b0;
  assign clr_addr  = '0;
  assign init_busy = 1'b0;
`endif

  assign acc      = ena & ~init_busy;
  assign wr       = acc & (|wea);
  assign rd       = acc & ~(|wea);
  assign in_range = {1'b0, addra} < DEPTH_C;

  // Array: the clear sweep owns the write port while it runs; out-of-range writes are dropped
  always_ff @(posedge clka) begin
    if (clr_we) begin
      mem[clr_addr] <= INIT_VALUE;
    end else if (wr && in_range) begin
      for (int i = 0; i < NB_COL; i++) begin
        if (wea[i]) mem[addra][i*COL_WIDTH +: COL_WIDTH] <= dina[i*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  // Stage 1: array read register, untouched by writes (no-change mode)
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      rdata_p1_q <= '0;
      vld_p1_q   <= 1'b0;
    end else begin
      vld_p1_q <= rd;
      if (rd) rdata_p1_q <= in_range ? mem[addra] : INIT_VALUE;
    end
  end

  if (RAM_LATENCY == 1) begin : g_lat1
    logic unused_regcea;
    assign unused_regcea = regcea;
    assign douta         = rdata_p1_q;
    assign douta_valid   = vld_p1_q;
  end else begin : g_lat2
    logic [RAM_WIDTH-1:0] rdata_p2_q;
    logic                 vld_p2_q;

    // Stage 2: output register; regcea low freezes data and valid, a pending stage-1 result may be overwritten
    always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
        rdata_p2_q <= '0;
        vld_p2_q   <= 1'b0;
      end else if (regcea) begin
        rdata_p2_q <= rdata_p1_q;
        vld_p2_q   <= vld_p1_q;
      end
    end

    assign douta       = rdata_p2_q;
    assign douta_valid = vld_p2_q;
  end

endmodule

// File: tb/tb_xilinx_single_port_ram_bytewe_pipe.sv
// Bench for xilinx_single_port_ram_bytewe_pipe: a latency-1 depth-10 instance and a latency-2
// depth-16 instance share stimulus and are each checked against an array-based reference model.
module tb_xilinx_single_port_ram_bytewe_pipe;

  localparam int D1 = 10;
  localparam int D2 = 16;
  localparam logic [31:0] INIT = 32'hC0FFEE5A;

  typedef struct packed {
    logic        e;
    logic [3:0]  w;
    logic [3:0]  a;
    logic [31:0] d;
    logic        rc;
  } stim_t;

  logic        clka = 1'b0;
  logic        rsta_n;
  logic        ena;
  logic [3:0]  wea;
  logic [3:0]  addra;
  logic [31:0] dina;
  logic        regcea;
  logic [31:0] d1, d2;
  logic        v1, v2, b1, b2;

  always #5 clka = ~clka;

  xilinx_single_port_ram_bytewe_pipe #(
    .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(D1), .RAM_LATENCY(1), .INIT_VALUE(INIT)
  ) u_l1 (
    .clka(clka), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .regcea(regcea), .douta(d1), .douta_valid(v1), .init_busy(b1)
  );

  xilinx_single_port_ram_bytewe_pipe #(
    .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(D2), .RAM_LATENCY(2), .INIT_VALUE(INIT)
  ) u_l2 (
    .clka(clka), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .regcea(regcea), .douta(d2), .douta_valid(v2), .init_busy(b2)
  );

  // Reference model: memory contents, last read result seen by each instance, and the
  // latency-2 output as a snapshot of its own latency-1 view taken on regcea edges.
  logic [31:0] m1 [D1];
  logic [31:0] m2 [D2];
  logic [31:0] rreg1, rreg2, o2_d;
  logic        pv1, pv2, o2_v;
  int          bc1, bc2;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic stim_t mk(logic e, logic [3:0] w, logic [3:0] a, logic [31:0] d, logic rc);
    stim_t s;
    s.e = e; s.w = w; s.a = a; s.d = d; s.rc = rc;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    ena = s.e; wea = s.w; addra = s.a; dina = s.d; regcea = s.rc;
  endtask

  task automatic model_reset();
    rreg1 = '0; rreg2 = '0; o2_d = '0;
    pv1 = 1'b0; pv2 = 1'b0; o2_v = 1'b0;
`ifdef RAM_CLEAR_ON_RESET_EN
    bc1 = D1; bc2 = D2;
    for (int k = 0; k < D1; k++) m1[k] = INIT;
    for (int k = 0; k < D2; k++) m2[k] = INIT;
`else
    bc1 = 0; bc2 = 0;
`endif
  endtask

  task automatic tick();
    logic acc1, acc2, rd1, rd2;
    acc1 = ena && (bc1 == 0);
    acc2 = ena && (bc2 == 0);
    rd1  = acc1 && (wea == 4'h0);
    rd2  = acc2 && (wea == 4'h0);
    for (int b = 0; b < 4; b++) begin
      if (acc1 && wea[b] && int'(addra) < D1) m1[addra][b*8 +: 8] = dina[b*8 +: 8];
      if (acc2 && wea[b] && int'(addra) < D2) m2[addra][b*8 +: 8] = dina[b*8 +: 8];
    end
    if (regcea) begin
      o2_d = rreg2;
      o2_v = pv2;
    end
    if (rd1) rreg1 = (int'(addra) < D1) ? m1[addra] : INIT;
    if (rd2) rreg2 = (int'(addra) < D2) ? m2[addra] : INIT;
    pv1 = rd1;
    pv2 = rd2;
    if (bc1 > 0) bc1--;
    if (bc2 > 0) bc2--;
    @(posedge clka);
    #1;
  endtask

  task automatic test_reset();
    ena = 1'b0; wea = '0; addra = '0; dina = '0; regcea = 1'b1;
    rsta_n = 1'b1;
    #2 rsta_n = 1'b0;
    #1 model_reset();
    n_cmp++; if (d1 !== 32'h0) begin n_err++; $display("FAIL reset_l1_douta act=%h exp=%h", d1, 32'h0); end
    n_cmp++; if (v1 !== 1'b0) begin n_err++; $display("FAIL reset_l1_valid act=%b exp=0", v1); end
    n_cmp++; if (d2 !== 32'h0) begin n_err++; $display("FAIL reset_l2_douta act=%h exp=%h", d2, 32'h0); end
    n_cmp++; if (v2 !== 1'b0) begin n_err++; $display("FAIL reset_l2_valid act=%b exp=0", v2); end
    n_cmp++; if (b1 !== (bc1 > 0)) begin n_err++; $display("FAIL reset_l1_busy act=%b exp=%b", b1, bc1 > 0); end
    n_cmp++; if (b2 !== (bc2 > 0)) begin n_err++; $display("FAIL reset_l2_busy act=%b exp=%b", b2, bc2 > 0); end
    @(posedge clka);
    #1 rsta_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(mk(1'b1, 4'hF, i[3:0], $urandom, 1'b1));
      tick();
      n_cmp++; if (b1 !== (bc1 > 0)) begin n_err++; $display("FAIL sweep_l1_busy act=%b exp=%b", b1, bc1 > 0); end
      n_cmp++; if (b2 !== (bc2 > 0)) begin n_err++; $display("FAIL sweep_l2_busy act=%b exp=%b", b2, bc2 > 0); end
    end
    rsta_n = 1'b0;
    #1 model_reset();
    n_cmp++; if (v1 !== 1'b0) begin n_err++; $display("FAIL rerst_l1_valid act=%b exp=0", v1); end
    n_cmp++; if (b2 !== (bc2 > 0)) begin n_err++; $display("FAIL rerst_l2_busy act=%b exp=%b", b2, bc2 > 0); end
    #1 rsta_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
`ifdef RAM_CLEAR_ON_RESET_EN
      if (i < 16) drive(mk(1'b1, 4'h0, i[3:0], 32'h0, 1'b1));
      else        drive(mk(1'b0, 4'h0, 4'h0, 32'h0, 1'b1));
`else
      drive(mk(1'b1, 4'hF, i[3:0], $urandom, 1'b1));
`endif
      tick();
      n_cmp++; if (b1 !== (bc1 > 0)) begin n_err++; $display("FAIL clear_l1_busy act=%b exp=%b", b1, bc1 > 0); end
      n_cmp++; if (b2 !== (bc2 > 0)) begin n_err++; $display("FAIL clear_l2_busy act=%b exp=%b", b2, bc2 > 0); end
      n_cmp++; if (d1 !== rreg1) begin n_err++; $display("FAIL clear_l1_douta act=%h exp=%h", d1, rreg1); end
      n_cmp++; if (v1 !== pv1) begin n_err++; $display("FAIL clear_l1_valid act=%b exp=%b", v1, pv1); end
      n_cmp++; if (d2 !== o2_d) begin n_err++; $display("FAIL clear_l2_douta act=%h exp=%h", d2, o2_d); end
      n_cmp++; if (v2 !== o2_v) begin n_err++; $display("FAIL clear_l2_valid act=%b exp=%b", v2, o2_v); end
    end
  endtask

  task automatic test_write_read();
    stim_t s[$];
    s.push_back(mk(1'b1, 4'hF, 4'd5, 32'hDEADBEEF, 1'b1));
    s.push_back(mk(1'b1, 4'h0, 4'd5, 32'h0, 1'b1));
    s.push_back(mk(1'b0, 4'h0, 4'd0, 32'h0, 1'b1));
    s.push_back(mk(1'b0, 4'h0, 4'd0, 32'h0, 1'b1));
    foreach (s[i]) begin
      drive(s[i]);
      tick();
      n_cmp++; if (d1 !== rreg1) begin n_err++; $display("FAIL wr_rd_l1_douta act=%h exp=%h", d1, rreg1); end
      n_cmp++; if (v1 !== pv1) begin n_err++; $display("FAIL wr_rd_l1_valid act=%b exp=%b", v1, pv1); end
      n_cmp++; if (d2 !== o2_d) begin n_err++; $display("FAIL wr_rd_l2_douta act=%h exp=%h", d2, o2_d); end
      n_cmp++; if (v2 !== o2_v) begin n_err++; $display("FAIL wr_rd_l2_valid act=%b exp=%b", v2, o2_v); end
      if (i == 1) begin
        n_cmp++; if (d1 !== 32'hDEADBEEF || v1 !== 1'b1) begin n_err++; $display("FAIL wr_rd_lat1 act=%h/%b exp=deadbeef/1", d1, v1); end
      end
      if (i == 2) begin
        n_cmp++; if (d2 !== 32'hDEADBEEF || v2 !== 1'b1 || v1 !== 1'b0) begin n_err++; $display("FAIL wr_rd_lat2 act=%h/%b/%b exp=deadbeef/1/0", d2, v2, v1); end
      end
    end
  endtask

  task automatic test_byte_enables();
    stim_t s[$];
    s.push_back(mk(1'b1, 4'b0101, 4'd5, 32'h11223344, 1'b1));
    s.push_back(mk(1'b1, 4'h0, 4'd5, 32'h0, 1'b1));
    s.push_back(mk(1'b0, 4'h0, 4'd0, 32'h0, 1'b1));
    s.push_back(mk(1'b0, 4'h0, 4'd0, 32'h0, 1'b1));
    foreach (s[i]) begin
      drive(s[i]);
      tick();
      n_cmp++; if (d1 !== rreg1) begin n_err++; $display("FAIL bytewe_l1_douta act=%h exp=%h", d1, rreg1); end
      n_cmp++; if (v1 !== pv1) begin n_err++; $display("FAIL bytewe_l1_valid act=%b exp=%b", v1, pv1); end
      n_cmp++; if (d2 !== o2_d) begin n_err++; $display("FAIL bytewe_l2_douta act=%h exp=%h", d2, o2_d); end
      n_cmp++; if (v2 !== o2_v) begin n_err++; $display("FAIL bytewe_l2_valid act=%b exp=%b", v2, o2_v); end
      if (i == 0) begin
        n_cmp++; if (d1 !== 32'hDEADBEEF || v1 !== 1'b0) begin n_err++; $display("FAIL bytewe_nochange act=%h/%b exp=deadbeef/0", d1, v1); end
      end
      if (i == 1) begin
        n_cmp++; if (d1 !== 32'hDE22BE44) begin n_err++; $display("FAIL bytewe_merge act=%h exp=de22be44", d1); end
      end
    end
  endtask

  task automatic test_regcea_stall();
    stim_t s[$];
    logic [1:0] seq_a [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic       seq_c [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int a = 0; a < 4; a++) s.push_back(mk(1'b1, 4'hF, a[3:0], $urandom, 1'b1));
    for (int k = 0; k < 8; k++) s.push_back(mk(1'b1, 4'h0, {2'b00, seq_a[k]}, 32'h0, seq_c[k]));
    s.push_back(mk(1'b0, 4'h0, 4'd0, 32'h0, 1'b1));
    s.push_back(mk(1'b0, 4'h0, 4'd0, 32'h0, 1'b1));
    foreach (s[i]) begin
      drive(s[i]);
      tick();
      n_cmp++; if (d1 !== rreg1) begin n_err++; $display("FAIL stall_l1_douta act=%h exp=%h", d1, rreg1); end
      n_cmp++; if (v1 !== pv1) begin n_err++; $display("FAIL stall_l1_valid act=%b exp=%b", v1, pv1); end
      n_cmp++; if (d2 !== o2_d) begin n_err++; $display("FAIL stall_l2_douta act=%h exp=%h", d2, o2_d); end
      n_cmp++; if (v2 !== o2_v) begin n_err++; $display("FAIL stall_l2_valid act=%b exp=%b", v2, o2_v); end
    end
  endtask

  task automatic test_out_of_range();
    stim_t s[$];
    s.push_back(mk(1'b1, 4'hF, 4'd2, 32'h0BADF00D, 1'b1));
    s.push_back(mk(1'b1, 4'hF, 4'd12, 32'hAAAA5555, 1'b1));
    s.push_back(mk(1'b1, 4'h0, 4'd12, 32'h0, 1'b1));
    s.push_back(mk(1'b1, 4'h0, 4'd2, 32'h0, 1'b1));
    s.push_back(mk(1'b0, 4'h0, 4'd0, 32'h0, 1'b1));
    s.push_back(mk(1'b0, 4'h0, 4'd0, 32'h0, 1'b1));
    foreach (s[i]) begin
      drive(s[i]);
      tick();
      n_cmp++; if (d1 !== rreg1) begin n_err++; $display("FAIL oor_l1_douta act=%h exp=%h", d1, rreg1); end
      n_cmp++; if (v1 !== pv1) begin n_err++; $display("FAIL oor_l1_valid act=%b exp=%b", v1, pv1); end
      n_cmp++; if (d2 !== o2_d) begin n_err++; $display("FAIL oor_l2_douta act=%h exp=%h", d2, o2_d); end
      n_cmp++; if (v2 !== o2_v) begin n_err++; $display("FAIL oor_l2_valid act=%b exp=%b", v2, o2_v); end
      if (i == 2) begin
        n_cmp++; if (d1 !== INIT || v1 !== 1'b1) begin n_err++; $display("FAIL oor_read_init act=%h/%b exp=%h/1", d1, v1, INIT); end
      end
      if (i == 3) begin
        n_cmp++; if (d1 !== 32'h0BADF00D) begin n_err++; $display("FAIL oor_alias act=%h exp=0badf00d", d1); end
        n_cmp++; if (d2 !== 32'hAAAA5555) begin n_err++; $display("FAIL oor_inrange_l2 act=%h exp=aaaa5555", d2); end
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    s.push_back(mk(1'b1, 4'hF, 4'd7, 32'h12345678, 1'b1));
    s.push_back(mk(1'b1, 4'h0, 4'd7, 32'h0, 1'b1));
    s.push_back(mk(1'b1, 4'hF, 4'd7, 32'h87654321, 1'b1));
    s.push_back(mk(1'b1, 4'h0, 4'd7, 32'h0, 1'b1));
    s.push_back(mk(1'b0, 4'h0, 4'd0, 32'h0, 1'b1));
    s.push_back(mk(1'b0, 4'h0, 4'd0, 32'h0, 1'b1));
    foreach (s[i]) begin
      drive(s[i]);
      tick();
      n_cmp++; if (d1 !== rreg1) begin n_err++; $display("FAIL b2b_l1_douta act=%h exp=%h", d1, rreg1); end
      n_cmp++; if (v1 !== pv1) begin n_err++; $display("FAIL b2b_l1_valid act=%b exp=%b", v1, pv1); end
      n_cmp++; if (d2 !== o2_d) begin n_err++; $display("FAIL b2b_l2_douta act=%h exp=%h", d2, o2_d); end
      n_cmp++; if (v2 !== o2_v) begin n_err++; $display("FAIL b2b_l2_valid act=%b exp=%b", v2, o2_v); end
      if (i == 2) begin
        n_cmp++; if (d2 !== 32'h12345678) begin n_err++; $display("FAIL b2b_old_data act=%h exp=12345678", d2); end
      end
      if (i == 3) begin
        n_cmp++; if (d1 !== 32'h87654321) begin n_err++; $display("FAIL b2b_new_data act=%h exp=87654321", d1); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      stim_t s;
      s.e  = ($urandom_range(0, 7) != 0);
      s.w  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      s.a  = 4'($urandom_range(0, 15));
      s.d  = $urandom;
      s.rc = ($urandom_range(0, 4) != 0);
      drive(s);
      tick();
      n_cmp++; if (d1 !== rreg1) begin n_err++; $display("FAIL rand_l1_douta act=%h exp=%h", d1, rreg1); end
      n_cmp++; if (v1 !== pv1) begin n_err++; $display("FAIL rand_l1_valid act=%b exp=%b", v1, pv1); end
      n_cmp++; if (d2 !== o2_d) begin n_err++; $display("FAIL rand_l2_douta act=%h exp=%h", d2, o2_d); end
      n_cmp++; if (v2 !== o2_v) begin n_err++; $display("FAIL rand_l2_valid act=%b exp=%b", v2, o2_v); end
      n_cmp++; if (b1 !== 1'b0 || b2 !== 1'b0) begin n_err++; $display("FAIL rand_busy act=%b%b exp=00", b1, b2); end
    end
  endtask

  task automatic test_reset_mid_read();
`ifdef RAM_CLEAR_ON_RESET_EN
    logic [31:0] exp_after = INIT;
`else
    logic [31:0] exp_after = 32'h5A5AA5A5;
`endif
    drive(mk(1'b1, 4'hF, 4'd9, 32'h5A5AA5A5, 1'b1));
    tick();
    drive(mk(1'b1, 4'h0, 4'd9, 32'h0, 1'b1));
    tick();
    rsta_n = 1'b0;
    #1 model_reset();
    n_cmp++; if (d1 !== 32'h0 || v1 !== 1'b0) begin n_err++; $display("FAIL midrst_l1 act=%h/%b exp=0/0", d1, v1); end
    n_cmp++; if (d2 !== 32'h0 || v2 !== 1'b0) begin n_err++; $display("FAIL midrst_l2 act=%h/%b exp=0/0", d2, v2); end
    n_cmp++; if (b2 !== (bc2 > 0)) begin n_err++; $display("FAIL midrst_busy act=%b exp=%b", b2, bc2 > 0); end
    #1 rsta_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(mk(1'b1, 4'h0, 4'd9, 32'h0, 1'b1));
      tick();
      n_cmp++; if (d1 !== rreg1) begin n_err++; $display("FAIL midrst_l1_douta act=%h exp=%h", d1, rreg1); end
      n_cmp++; if (v1 !== pv1) begin n_err++; $display("FAIL midrst_l1_valid act=%b exp=%b", v1, pv1); end
      n_cmp++; if (d2 !== o2_d) begin n_err++; $display("FAIL midrst_l2_douta act=%h exp=%h", d2, o2_d); end
      n_cmp++; if (v2 !== o2_v) begin n_err++; $display("FAIL midrst_l2_valid act=%b exp=%b", v2, o2_v); end
      n_cmp++; if (b2 !== (bc2 > 0)) begin n_err++; $display("FAIL midrst_l2_busy act=%b exp=%b", b2, bc2 > 0); end
    end
    n_cmp++; if (d2 !== exp_after || v2 !== 1'b1) begin n_err++; $display("FAIL midrst_final act=%h/%b exp=%h/1", d2, v2, exp_after); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enables();
    test_regcea_stall();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
